// File: rtl/tlc_pkg.sv
// Shared types and default timing for the intersection scheduler.
// Lamp codes, phase encoding and duration helpers live here so the bench sees the same encoding.
package tlc_pkg;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_GREEN  = 2'd1,
    LAMP_YELLOW = 2'd2
  } lamp_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    WALK      = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_B = 3'd6
  } phase_t;

  localparam int DEF_MIN_GREEN    = 8;
  localparam int DEF_YELLOW_CYC   = 3;
  localparam int DEF_ALL_RED_CYC  = 2;
  localparam int DEF_EW_GREEN_CYC = 6;
  localparam int DEF_WALK_CYC     = 5;

  localparam int TIMER_W = 16;

  // Last timer value of a phase lasting dur cycles; zero-length phases become one cycle.
  function automatic logic [TIMER_W-1:0] dur_limit(input int dur);
    logic [TIMER_W-1:0] lim;
    if (dur < 1) lim = '0;
    else         lim = TIMER_W'(dur - 1);
    return lim;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on a phase change, counts up, and stops at sat_at.
// expired is high while the count sits at (or past) the saturation value.
module phase_timer
  import tlc_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] sat_at,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count < sat_at) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= sat_at);

endmodule

// File: rtl/intersection_scheduler.sv
// Main-street-priority traffic controller with an east-west side street and a pedestrian walk phase.
// All lamp outputs are decoded from the registered phase; the timer counts cycles within a phase.
module intersection_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int YELLOW_CYC   = DEF_YELLOW_CYC,
  parameter int ALL_RED_CYC  = DEF_ALL_RED_CYC,
  parameter int EW_GREEN_CYC = DEF_EW_GREEN_CYC,
  parameter int WALK_CYC     = DEF_WALK_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] LIM_MIN_GREEN = dur_limit(MIN_GREEN);
  localparam logic [TIMER_W-1:0] LIM_YELLOW    = dur_limit(YELLOW_CYC);
  localparam logic [TIMER_W-1:0] LIM_ALL_RED   = dur_limit(ALL_RED_CYC);
  localparam logic [TIMER_W-1:0] LIM_EW_GREEN  = dur_limit(EW_GREEN_CYC);
  localparam logic [TIMER_W-1:0] LIM_WALK      = dur_limit(WALK_CYC);

  phase_t               cur_phase;
  phase_t               nxt_phase;
  logic                 ew_pend;
  logic                 ped_pend;
  logic                 phase_change;
  logic                 enter_ew;
  logic                 enter_walk;
  logic [TIMER_W-1:0]   sat_at;
  logic [TIMER_W-1:0]   count;
  logic                 expired;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst     (reset),
    .clear   (phase_change),
    .sat_at  (sat_at),
    .count   (count),
    .expired (expired)
  );

  // In NS_GREEN the saturation value doubles as the minimum-green point.
  always_comb begin
    sat_at = LIM_ALL_RED;
    case (cur_phase)
      NS_GREEN:            sat_at = LIM_MIN_GREEN;
      NS_YELLOW,
      EW_YELLOW:           sat_at = LIM_YELLOW;
      ALL_RED_A,
      ALL_RED_B:           sat_at = LIM_ALL_RED;
      WALK:                sat_at = LIM_WALK;
      EW_GREEN:            sat_at = LIM_EW_GREEN;
      default:             sat_at = LIM_ALL_RED;
    endcase
  end

  always_comb begin
    nxt_phase = cur_phase;
    case (cur_phase)
      NS_GREEN:  if (expired && (ew_pend || ped_pend)) nxt_phase = NS_YELLOW;
      NS_YELLOW: if (expired) nxt_phase = ALL_RED_A;
      ALL_RED_A: if (expired) nxt_phase = ped_pend ? WALK : EW_GREEN;
      WALK:      if (expired) nxt_phase = ew_pend ? EW_GREEN : NS_GREEN;
      EW_GREEN:  if (expired) nxt_phase = EW_YELLOW;
      EW_YELLOW: if (expired) nxt_phase = ALL_RED_B;
      ALL_RED_B: if (expired) nxt_phase = NS_GREEN;
      default:   nxt_phase = ALL_RED_B;
    endcase
  end

  assign phase_change = (nxt_phase != cur_phase);
  assign enter_ew     = (nxt_phase == EW_GREEN) && (cur_phase != EW_GREEN);
  assign enter_walk   = (nxt_phase == WALK) && (cur_phase != WALK);

  // A request arriving on the entry edge is absorbed by the service it is about to get.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_phase <= ALL_RED_B;
      ew_pend   <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      cur_phase <= nxt_phase;
      ew_pend   <= enter_ew   ? 1'b0 : (ew_pend  | car_ew);
      ped_pend  <= enter_walk ? 1'b0 : (ped_pend | ped_req);
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (cur_phase)
      NS_GREEN:  ns_light = LAMP_GREEN;
      NS_YELLOW: ns_light = LAMP_YELLOW;
      EW_GREEN:  ew_light = LAMP_GREEN;
      EW_YELLOW: ew_light = LAMP_YELLOW;
      WALK:      walk     = 1'b1;
      default:   ;
    endcase
  end

  assign ped_ack = (cur_phase == WALK) && (count == '0);
  assign phase   = cur_phase;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench: each scenario pushes its cycle-by-cycle expected trace into a queue;
// a negedge monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_intersection_scheduler;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  intersection_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .car_ew   (car_ew),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Vector layout: {phase[2:0], ns[1:0], ew[1:0], walk, ped_ack}
  logic [8:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  int idx = 0;
  int drain_errs = 0;
  int drain_seen = 0;

  function automatic logic [8:0] exp_vec(input phase_t ph, input logic ack);
    logic [1:0] ns;
    logic [1:0] ew;
    logic       wk;
    ns = (ph == NS_GREEN) ? 2'd1 : (ph == NS_YELLOW) ? 2'd2 : 2'd0;
    ew = (ph == EW_GREEN) ? 2'd1 : (ph == EW_YELLOW) ? 2'd2 : 2'd0;
    wk = (ph == WALK);
    return {ph, ns, ew, wk, ack};
  endfunction

  task automatic push_phase(input phase_t ph, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(ph, (ph == WALK) && (i == 0)));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    for (int i = 0; i < hold; i++) exp_q.push_back(exp_vec(ALL_RED_B, 1'b0));
    step(hold);
    reset = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      drain_errs++;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    logic [8:0] a;
    if (drain_errs != drain_seen) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout got %0d stalls required 0", drain_errs);
      drain_seen = drain_errs;
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {phase, ns_light, ew_light, walk, ped_ack};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL trace[%0d] got ph=%0d ns=%0d ew=%0d walk=%0b ack=%0b required ph=%0d ns=%0d ew=%0d walk=%0b ack=%0b",
                 idx, a[8:6], a[5:4], a[3:2], a[1], a[0], e[8:6], e[5:4], e[3:2], e[1], e[0]);
      end
      idx++;
    end
  end

  initial begin
    // Idle: reset state, then all-red 2 and NS_GREEN held with no requests.
    apply_reset(3);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 100);
    drain();

    // Single car_ew pulse in NS_GREEN cycle 3 runs one full EW cycle.
    apply_reset(1);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(EW_GREEN, 6);
    push_phase(EW_YELLOW, 3);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 10);
    step(4);
    car_ew = 1'b1;
    step(1);
    car_ew = 1'b0;
    drain();

    // Pedestrian only: WALK 5 with ack on its first cycle, then back to NS.
    apply_reset(1);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(WALK, 5);
    push_phase(NS_GREEN, 10);
    step(4);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    drain();

    // Both in the same cycle: WALK then EW_GREEN, each served once.
    apply_reset(1);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(WALK, 5);
    push_phase(EW_GREEN, 6);
    push_phase(EW_YELLOW, 3);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 12);
    step(4);
    car_ew  = 1'b1;
    ped_req = 1'b1;
    step(1);
    car_ew  = 1'b0;
    ped_req = 1'b0;
    drain();

    // car_ew held through EW_GREEN re-arms the request: NS green lasts exactly 8.
    apply_reset(1);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(EW_GREEN, 6);
    push_phase(EW_YELLOW, 3);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(EW_GREEN, 6);
    push_phase(EW_YELLOW, 3);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 10);
    step(4);
    car_ew = 1'b1;
    step(17);
    car_ew = 1'b0;
    drain();

    // Reset in EW_GREEN cycle 2 with ped_pend set: immediate red, pending walk discarded.
    apply_reset(1);
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 8);
    push_phase(NS_YELLOW, 3);
    push_phase(ALL_RED_A, 2);
    push_phase(EW_GREEN, 1);
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_vec(ALL_RED_B, 1'b0));
    push_phase(ALL_RED_B, 2);
    push_phase(NS_GREEN, 30);
    step(4);
    car_ew = 1'b1;
    step(1);
    car_ew = 1'b0;
    step(10);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    reset   = 1'b1;
    step(3);
    reset = 1'b0;
    drain();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
